fp_norm_shift_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational normalize-shift stage of the FP add/sub datapath. Takes the pre-shifted sum plus guard/pre-sticky bits and produces the final normalized mantissa, adjusted exponent, flags and round/sticky bits. Unlike the prior stage, it applies the carry (MSB) correction itself. It sits between the leading-zero shift stage and the rounding stage, with a valid/ready handshake on both sides.

---
 rtl/fp_norm_shift_pipe.sv | 171 +++++++++++++++++
 tb/tb_fp_norm_shift_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_shift_pipe.sv
// rtl/fp_norm_shift_pipe.sv - two-stage normalize/carry-correct stage of the FP add/sub datapath
// Optional FP_NORM_SKID_EN: registered in_ready with a one-entry skid buffer ahead of S1.
module fp_norm_shift_pipe #(
  parameter int MANT_W = 23,
  parameter int EXP_W = 8,
  parameter int SHIFT_W = 5,
  localparam int SUM_W = MANT_W + 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SUM_W-1:0]   ps_sum,
  input  logic               g,
  input  logic               ps,
  input  logic [EXP_W-1:0]   c_exp,
  input  logic [SHIFT_W-1:0] shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MANT_W-1:0]  norm_m,
  output logic [EXP_W:0]     norm_e,
  output logic               zero_sum,
  output logic               neg_e,
  output logic               ovf_e,
  output logic               r,
  output logic               s
);

  localparam logic [EXP_W:0] OVF_LIM = {1'b0, {EXP_W{1'b1}}};

  logic               v1;
  logic [SUM_W-1:0]   s1_sum;
  logic               s1_g;
  logic               s1_ps;
  logic [EXP_W-1:0]   s1_exp;
  logic [SHIFT_W-1:0] s1_shift;

  logic s2_load;
  logic s1_load;
  logic accept;

  logic               src_valid;
  logic [SUM_W-1:0]   src_sum;
  logic               src_g;
  logic               src_ps;
  logic [EXP_W-1:0]   src_exp;
  logic [SHIFT_W-1:0] src_shift;

  assign s2_load = ~out_valid | out_ready;
  assign s1_load = ~v1 | s2_load;

`ifdef FP_NORM_SKID_EN
  logic               sk_v;
  logic [SUM_W-1:0]   sk_sum;
  logic               sk_g;
  logic               sk_ps;
  logic [EXP_W-1:0]   sk_exp;
  logic [SHIFT_W-1:0] sk_shift;

  // Ready is low exactly while the skid holds a beat, so a full skid never sees a new accept.
  assign in_ready  = ~sk_v;
  assign accept    = in_valid & in_ready;
  assign src_valid = sk_v | accept;
  assign src_sum   = sk_v ? sk_sum   : ps_sum;
  assign src_g     = sk_v ? sk_g     : g;
  assign src_ps    = sk_v ? sk_ps    : ps;
  assign src_exp   = sk_v ? sk_exp   : c_exp;
  assign src_shift = sk_v ? sk_shift : shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      sk_v     <= 1'b0;
      sk_sum   <= '0;
      sk_g     <= 1'b0;
      sk_ps    <= 1'b0;
      sk_exp   <= '0;
      sk_shift <= '0;
    end else if (s1_load) begin
      sk_v <= 1'b0;
    end else if (accept) begin
      sk_v     <= 1'b1;
      sk_sum   <= ps_sum;
      sk_g     <= g;
      sk_ps    <= ps;
      sk_exp   <= c_exp;
      sk_shift <= shift;
    end
  end
`else
  assign in_ready  = s1_load;
  assign accept    = in_valid & in_ready;
  assign src_valid = accept;
  assign src_sum   = ps_sum;
  assign src_g     = g;
  assign src_ps    = ps;
  assign src_exp   = c_exp;
  assign src_shift = shift;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      s1_sum   <= '0;
      s1_g     <= 1'b0;
      s1_ps    <= 1'b0;
      s1_exp   <= '0;
      s1_shift <= '0;
    end else if (s1_load) begin
      v1 <= src_valid;
      if (src_valid) begin
        s1_sum   <= src_sum;
        s1_g     <= src_g;
        s1_ps    <= src_ps;
        s1_exp   <= src_exp;
        s1_shift <= src_shift;
      end
    end
  end

  logic               carry;
  logic               zero_c;
  logic [EXP_W+1:0]   e_wide;
  logic [MANT_W-1:0]  m_c;
  logic               r_c;
  logic               s_c;
  logic               ovf_c;

  // One extra headroom bit keeps c_exp=max plus carry distinguishable from a true negative.
  assign carry  = s1_sum[SUM_W-1];
  assign zero_c = ~|s1_sum;
  assign e_wide = {2'b00, s1_exp}
                - {{(EXP_W+2-SHIFT_W){1'b0}}, s1_shift}
                + {{(EXP_W+1){1'b0}}, carry};
  assign ovf_c  = ~e_wide[EXP_W+1] & (e_wide[EXP_W:0] >= OVF_LIM);

  always_comb begin
    m_c = s1_sum[MANT_W:1];
    r_c = s1_sum[0];
    s_c = s1_g | s1_ps;
    if (carry) begin
      m_c = s1_sum[MANT_W+1:2];
      r_c = s1_sum[1];
      s_c = s1_sum[0] | s1_g | s1_ps;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      norm_m    <= '0;
      norm_e    <= '0;
      zero_sum  <= 1'b0;
      ovf_e     <= 1'b0;
      r         <= 1'b0;
      s         <= 1'b0;
    end else if (s2_load) begin
      out_valid <= v1;
      if (v1) begin
        zero_sum <= zero_c;
        norm_m   <= zero_c ? '0 : m_c;
        norm_e   <= zero_c ? '0 : e_wide[EXP_W:0];
        ovf_e    <= ~zero_c & ovf_c;
        r        <= ~zero_c & r_c;
        s        <= ~zero_c & s_c;
      end
    end
  end

  assign neg_e = norm_e[EXP_W];

endmodule

// File: tb/tb_fp_norm_shift_pipe.sv
// tb/tb_fp_norm_shift_pipe.sv - directed vector bench for fp_norm_shift_pipe
// Expects 3 beats before in_ready drops when FP_NORM_SKID_EN is defined, else 2.
module tb_fp_norm_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] ps_sum;
  logic        g;
  logic        ps;
  logic [7:0]  c_exp;
  logic [4:0]  shift;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] norm_m;
  logic [8:0]  norm_e;
  logic        zero_sum;
  logic        neg_e;
  logic        ovf_e;
  logic        r;
  logic        s;

  fp_norm_shift_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .ps_sum(ps_sum), .g(g), .ps(ps), .c_exp(c_exp), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready),
    .norm_m(norm_m), .norm_e(norm_e), .zero_sum(zero_sum),
    .neg_e(neg_e), .ovf_e(ovf_e), .r(r), .s(s)
  );

  always #5 clk = ~clk;

`ifdef FP_NORM_SKID_EN
  localparam int EXP_ACC = 3;
`else
  localparam int EXP_ACC = 2;
`endif

  typedef struct {
    logic [25:0] ps_sum;
    logic        g;
    logic        ps;
    logic [7:0]  c_exp;
    logic [4:0]  shift;
    logic [22:0] m;
    logic [8:0]  e;
    logic        z;
    logic        n;
    logic        o;
    logic        r;
    logic        s;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [25:0] sum_i, input logic g_i, input logic ps_i,
                       input logic [7:0] e_i, input logic [4:0] sh_i);
    ps_sum = sum_i;
    g      = g_i;
    ps     = ps_i;
    c_exp  = e_i;
    shift  = sh_i;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(v.ps_sum, v.g, v.ps, v.c_exp, v.shift);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_m"}, 32'(norm_m), 32'(v.m));
    chk({tag, "_e"}, 32'(norm_e), 32'(v.e));
    chk({tag, "_z"}, 32'(zero_sum), 32'(v.z));
    chk({tag, "_neg"}, 32'(neg_e), 32'(v.n));
    chk({tag, "_ovf"}, 32'(ovf_e), 32'(v.o));
    chk({tag, "_r"}, 32'(r), 32'(v.r));
    chk({tag, "_s"}, 32'(s), 32'(v.s));
    @(posedge clk); #1;
  endtask

  vec_t vecs[12];

  initial begin
    int idx;
    int got;
    int first_low;
    int seen;
    logic prev_stall;
    logic [22:0] prev_m;
    logic [8:0]  prev_e;

    //              ps_sum        g  ps c_exp  sh   m            e       z  n  o  r  s
    vecs[0]  = '{26'h1000000, 0, 0, 8'd127, 5'd0, 23'h0,      9'd127, 0, 0, 0, 0, 0};
    vecs[1]  = '{26'h2000003, 0, 0, 8'd127, 5'd0, 23'h0,      9'd128, 0, 0, 0, 1, 1};
    vecs[2]  = '{26'h1000001, 1, 0, 8'd3,   5'd5, 23'h0,      9'h1FE, 0, 1, 0, 1, 1};
    vecs[3]  = '{26'h0000000, 1, 1, 8'd200, 5'd0, 23'h0,      9'd0,   1, 0, 0, 0, 0};
    vecs[4]  = '{26'h2000000, 0, 0, 8'd255, 5'd0, 23'h0,      9'd256, 0, 1, 1, 0, 0};
    vecs[5]  = '{26'h2000000, 0, 0, 8'd4,   5'd5, 23'h0,      9'd0,   0, 0, 0, 0, 0};
    vecs[6]  = '{26'h1ABCDEF, 0, 0, 8'd100, 5'd3, 23'h55E6F7, 9'd97,  0, 0, 0, 1, 0};
    vecs[7]  = '{26'h3FFFFFE, 0, 0, 8'd10,  5'd0, 23'h7FFFFF, 9'd11,  0, 0, 0, 1, 0};
    vecs[8]  = '{26'h1000000, 0, 0, 8'd255, 5'd0, 23'h0,      9'd255, 0, 0, 1, 0, 0};
    vecs[9]  = '{26'h1000000, 0, 0, 8'd254, 5'd0, 23'h0,      9'd254, 0, 0, 0, 0, 0};
    vecs[10] = '{26'h1000000, 0, 1, 8'd50,  5'd2, 23'h0,      9'd48,  0, 0, 0, 0, 1};
    vecs[11] = '{26'h0000000, 0, 0, 8'd0,   5'd31, 23'h0,     9'd0,   1, 0, 0, 0, 0};

    // Reset with a beat offered throughout; it must not be taken.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    drive(26'h1000002, 0, 0, 8'd77, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_norm_m", 32'(norm_m), 32'd0);
    chk("rst_norm_e", 32'(norm_e), 32'd0);
    chk("rst_flags", 32'({zero_sum, neg_e, ovf_e, r, s}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rst_no_beat", 32'(seen), 32'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Stream 6 beats with the output stalled for the first 4 cycles.
    idx = 0; got = 0; first_low = -1; prev_stall = 1'b0; prev_m = '0; prev_e = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (idx < 6);
      drive(26'h1000000 | 26'((idx + 1) << 1), 0, 0, 8'(10 + idx), 5'd0);
      #1;
      if (prev_stall) begin
        chk("stall_hold_valid", 32'(out_valid), 32'd1);
        chk("stall_hold_m", 32'(norm_m), 32'(prev_m));
        chk("stall_hold_e", 32'(norm_e), 32'(prev_e));
      end
      if (!in_ready && first_low < 0) first_low = idx;
      if (out_valid && out_ready) begin
        chk("stream_m", 32'(norm_m), 32'(got + 1));
        chk("stream_e", 32'(norm_e), 32'(10 + got));
        got++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_m = norm_m;
      prev_e = norm_e;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_count", 32'(got), 32'd6);
    chk("ready_drop_after", 32'(first_low), 32'(EXP_ACC));

    // Two beats in flight, then reset with a third beat offered.
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(26'h1000022, 0, 0, 8'd20, 5'd0);
    @(posedge clk); #1;
    drive(26'h1000024, 0, 0, 8'd21, 5'd0);
    @(posedge clk); #1;
    chk("inflight_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    drive(26'h1000066, 0, 0, 8'd22, 5'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_norm_m", 32'(norm_m), 32'd0);
    chk("midrst_norm_e", 32'(norm_e), 32'd0);
    chk("midrst_flags", 32'({zero_sum, neg_e, ovf_e, r, s}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_flushed", 32'(seen), 32'd0);
    run_vec(vecs[6], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
